// File: rtl/kryon_pkg.sv
// kryon_pkg: window field layout and derived widths shared by the line buffers.
package kryon_pkg;

    function automatic int field_off(input int r, input int c, input int ch,
                                     input int w, input int chans, input int dw);
        return ((r * w + c) * chans + ch) * dw;
    endfunction

    function automatic int ram_word_w(input int h, input int chans, input int dw);
        return (h - 1) * chans * dw;
    endfunction

    function automatic int win_w(input int h, input int w, input int chans, input int dw);
        return h * w * chans * dw;
    endfunction

    localparam int RAM_WORD_W = ram_word_w(3, 1, 8);
    localparam int WIN_W      = win_w(3, 3, 1, 8);

endpackage

// File: rtl/line_ram.sv
// line_ram: simple dual-port inferred RAM, one write port and a registered read port.
module line_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[raddr];
    end

    assign rdata = rd_q;
endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: raster stream to OPERATOR_HEIGHT x OPERATOR_WIDTH window with
// border validity, zero-fill, line counting and line-overflow detection.
module window_line_buffer
    import kryon_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int CHANNELS        = 1,
    parameter int ADDR_WIDTH      = 11,
    parameter int OPERATOR_HEIGHT = 3,
    parameter int OPERATOR_WIDTH  = 3,
    parameter int LCNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  FrameStart,
    input  logic                  DataEn,
    input  logic [CHANNELS*DATA_WIDTH-1:0] PixelData,
    output logic                  OperatorDataEn,
    output logic [OPERATOR_HEIGHT*OPERATOR_WIDTH*CHANNELS*DATA_WIDTH-1:0] OperatorData,
    output logic [OPERATOR_HEIGHT-1:0] RowValid,
    output logic [OPERATOR_WIDTH-1:0]  ColValid,
    output logic                  WindowValid,
    output logic [LCNT_WIDTH-1:0] LineCount,
    output logic                  Overflow
);
    localparam int H  = OPERATOR_HEIGHT;
    localparam int W  = OPERATOR_WIDTH;
    localparam int SW = CHANNELS * DATA_WIDTH;
    localparam int RW = ram_word_w(H, CHANNELS, DATA_WIDTH);
    localparam int WW = win_w(H, W, CHANNELS, DATA_WIDTH);

    logic                  en1_q, en2_q, skip_q, skip_d, ovf_q, ovf_d, wv_q, wv_d;
    logic                  start, fs_ok, wrap, line_end, first;
    logic [SW-1:0]         pix1_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, a1_q, a2_q, raddr;
    logic [LCNT_WIDTH-1:0] lcnt_q, lcnt_d;
    logic [H-1:0]          row_q, row_d;
    logic [W-1:0]          col_q, col_d;
    logic [WW-1:0]         win_q, win_d;
    logic [RW-1:0]         rdata, wdata;

    always_comb begin
        start    = DataEn & ~en1_q;
        fs_ok    = FrameStart & (~DataEn | start);
        raddr    = start ? '0 : addr_q + ADDR_WIDTH'(1);
        addr_d   = DataEn ? raddr : addr_q;
        wrap     = DataEn & ~start & (&addr_q);
        line_end = en2_q & ~en1_q;
        first    = en1_q & ~en2_q;
        // a frame start in the gap must not let the draining previous line bump the count
        skip_d   = fs_ok ? en1_q : (line_end ? 1'b0 : skip_q);
        lcnt_d   = fs_ok ? '0 : (line_end & ~skip_q & ~(&lcnt_q)) ? lcnt_q + LCNT_WIDTH'(1) : lcnt_q;
        ovf_d    = fs_ok ? 1'b0 : ovf_q | wrap;
        row_d    = row_q;
        col_d    = col_q;
        win_d    = win_q;
        wv_d     = 1'b0;
        if (en1_q) begin
            for (int r = 0; r < H; r++) row_d[r] = lcnt_q >= LCNT_WIDTH'(H - 1 - r);
            for (int c = 0; c < W - 1; c++) col_d[c] = ~first & col_q[c+1];
            col_d[W-1] = 1'b1;
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W - 1; c++)
                    win_d[field_off(r, c, 0, W, CHANNELS, DATA_WIDTH) +: SW] =
                        first ? '0 : win_q[field_off(r, c + 1, 0, W, CHANNELS, DATA_WIDTH) +: SW];
            for (int r = 0; r < H - 1; r++)
                win_d[field_off(r, W - 1, 0, W, CHANNELS, DATA_WIDTH) +: SW] =
                    row_d[r] ? rdata[r*SW +: SW] : '0;
            win_d[field_off(H - 1, W - 1, 0, W, CHANNELS, DATA_WIDTH) +: SW] = pix1_q;
            wv_d = (&row_d) & (&col_d);
        end
        // the newest column moves up one row for the next line; row 0 falls off
        for (int r = 1; r < H; r++)
            wdata[(r-1)*SW +: SW] = win_q[field_off(r, W - 1, 0, W, CHANNELS, DATA_WIDTH) +: SW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en1_q  <= 1'b0;
            en2_q  <= 1'b0;
            skip_q <= 1'b0;
            ovf_q  <= 1'b0;
            wv_q   <= 1'b0;
            pix1_q <= '0;
            addr_q <= '0;
            a1_q   <= '0;
            a2_q   <= '0;
            lcnt_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            win_q  <= '0;
        end else begin
            en1_q  <= DataEn;
            en2_q  <= en1_q;
            skip_q <= skip_d;
            ovf_q  <= ovf_d;
            wv_q   <= wv_d;
            pix1_q <= PixelData;
            addr_q <= addr_d;
            a1_q   <= raddr;
            a2_q   <= a1_q;
            lcnt_q <= lcnt_d;
            row_q  <= row_d;
            col_q  <= col_d;
            win_q  <= win_d;
        end
    end

    line_ram #(.AW(ADDR_WIDTH), .DW(RW)) u_ram (
        .clk  (clk),
        .we   (en2_q),
        .waddr(a2_q),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign OperatorDataEn = en2_q;
    assign OperatorData   = win_q;
    assign RowValid       = row_q;
    assign ColValid       = col_q;
    assign WindowValid    = wv_q;
    assign LineCount      = lcnt_q;
    assign Overflow       = ovf_q;
endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: directed checks of the 3x3 window buffer, scalar and RGB builds.
module tb_window_line_buffer;
    logic        clk = 1'b0, rst = 1'b1, fs = 1'b0, den = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic [23:0] pix3;
    logic        oen, wv, ovf, oen3, wv3, ovf3;
    logic [71:0] od;
    logic [215:0] od3;
    logic [2:0]  rv, cv, rv3, cv3;
    logic [15:0] lc, lc3;

    int total = 0, bad = 0;
    int ob = -1, oc = 0;
    logic en_prev = 1'b0;
    logic [71:0]  cap_d  [32][20];
    logic [215:0] cap3   [32][20];
    logic [2:0]   cap_rv [32][20];
    logic [2:0]   cap_cv [32][20];
    logic         cap_wv [32][20];

    assign pix3 = {pix ^ 8'hAA, pix ^ 8'hBB, pix ^ 8'hCC};

    always #5 clk = ~clk;

    window_line_buffer #(.DATA_WIDTH(8), .CHANNELS(1), .ADDR_WIDTH(4),
                         .OPERATOR_HEIGHT(3), .OPERATOR_WIDTH(3), .LCNT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .FrameStart(fs), .DataEn(den), .PixelData(pix),
        .OperatorDataEn(oen), .OperatorData(od), .RowValid(rv), .ColValid(cv),
        .WindowValid(wv), .LineCount(lc), .Overflow(ovf));

    window_line_buffer #(.DATA_WIDTH(8), .CHANNELS(3), .ADDR_WIDTH(4),
                         .OPERATOR_HEIGHT(3), .OPERATOR_WIDTH(3), .LCNT_WIDTH(16)) u3 (
        .clk(clk), .rst(rst), .FrameStart(fs), .DataEn(den), .PixelData(pix3),
        .OperatorDataEn(oen3), .OperatorData(od3), .RowValid(rv3), .ColValid(cv3),
        .WindowValid(wv3), .LineCount(lc3), .Overflow(ovf3));

    // each output burst (one line) is filed under its own index
    always @(negedge clk) begin
        if (oen) begin
            if (!en_prev) begin
                ob = ob + 1;
                oc = 0;
            end else oc = oc + 1;
            if (ob >= 0 && ob < 32 && oc < 20) begin
                cap_d[ob][oc]  = od;
                cap3[ob][oc]   = od3;
                cap_rv[ob][oc] = rv;
                cap_cv[ob][oc] = cv;
                cap_wv[ob][oc] = wv;
            end
        end
        en_prev = oen;
    end

    function automatic logic [8:0] mdl(input int ln, input int col, input int r, input int c);
        logic v;
        v = (ln >= 2 - r) && (col >= 2 - c);
        return {v, v ? 8'(16 * (ln - 2 + r) + (col - 2 + c)) : 8'd0};
    endfunction

    function automatic logic [71:0] exp_win(input int ln, input int col);
        logic [71:0] v;
        logic [8:0]  m;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                m = mdl(ln, col, r, c);
                v[(r*3+c)*8 +: 8] = m[7:0];
            end
        return v;
    endfunction

    function automatic logic [215:0] exp_win3(input int ln, input int col);
        logic [215:0] v;
        logic [8:0]   m;
        logic [7:0]   k;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int ch = 0; ch < 3; ch++) begin
                    m = mdl(ln, col, r, c);
                    k = (ch == 0) ? 8'hCC : (ch == 1) ? 8'hBB : 8'hAA;
                    v[((r*3+c)*3+ch)*8 +: 8] = m[8] ? (m[7:0] ^ k) : 8'd0;
                end
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int ln, input int w, input int fs_col, input int gap);
        for (int col = 0; col < w; col++) begin
            den = 1'b1;
            pix = 8'(16 * ln + col);
            fs  = (col == fs_col);
            step;
        end
        den = 1'b0;
        fs  = 1'b0;
        pix = 8'd0;
        repeat (gap) step;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step;
        total += 7;
        if (oen !== 1'b0) begin bad++; $display("FAIL reset_oen got=%b exp=0", oen); end
        if (od !== 72'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", od); end
        if (rv !== 3'b000) begin bad++; $display("FAIL reset_rowvalid got=%b exp=000", rv); end
        if (cv !== 3'b000) begin bad++; $display("FAIL reset_colvalid got=%b exp=000", cv); end
        if (wv !== 1'b0) begin bad++; $display("FAIL reset_wv got=%b exp=0", wv); end
        if (lc !== 16'd0) begin bad++; $display("FAIL reset_linecount got=%0d exp=0", lc); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_line0;
        int b0;
        b0 = ob + 1;
        den = 1'b1; fs = 1'b1; pix = 8'd0;
        step;
        total++;
        if (oen !== 1'b0) begin bad++; $display("FAIL lat_cycle1 got=%b exp=0", oen); end
        fs = 1'b0; pix = 8'd1;
        step;
        total += 5;
        if (oen !== 1'b1) begin bad++; $display("FAIL lat_cycle2 got=%b exp=1", oen); end
        if (od !== 72'd0) begin bad++; $display("FAIL line0_first_data got=%h exp=0", od); end
        if (rv !== 3'b100) begin bad++; $display("FAIL line0_rowvalid got=%b exp=100", rv); end
        if (cv !== 3'b100) begin bad++; $display("FAIL line0_colvalid got=%b exp=100", cv); end
        if (wv !== 1'b0) begin bad++; $display("FAIL line0_wv got=%b exp=0", wv); end
        pix = 8'd2;
        step;
        total += 2;
        if (od !== 72'h010000000000000000) begin bad++; $display("FAIL line0_second_data got=%h exp=010000000000000000", od); end
        if (cv !== 3'b110) begin bad++; $display("FAIL line0_colvalid2 got=%b exp=110", cv); end
        pix = 8'd3;
        step;
        den = 1'b0; pix = 8'd0;
        repeat (3) step;
        total += 3;
        if (lc !== 16'd1) begin bad++; $display("FAIL line0_linecount got=%0d exp=1", lc); end
        if (cap_d[b0][3] !== exp_win(0, 3)) begin bad++; $display("FAIL line0_last_data got=%h exp=%h", cap_d[b0][3], exp_win(0, 3)); end
        if (wv !== 1'b0) begin bad++; $display("FAIL idle_wv got=%b exp=0", wv); end
    endtask

    task automatic test_three_lines;
        int b0;
        b0 = ob + 1;
        drive_line(0, 4, 0, 1);
        drive_line(1, 4, -1, 1);
        drive_line(2, 4, -1, 3);
        total += 4;
        if (ob - b0 + 1 !== 3) begin bad++; $display("FAIL three_bursts got=%0d exp=3", ob - b0 + 1); end
        if (lc !== 16'd3) begin bad++; $display("FAIL three_linecount got=%0d exp=3", lc); end
        if (cap_d[b0+2][2] !== 72'h22_21_20_12_11_10_02_01_00) begin bad++; $display("FAIL l2c2_window got=%h exp=222120121110020100", cap_d[b0+2][2]); end
        if (cap_d[b0+2][3] !== 72'h23_22_21_13_12_11_03_02_01) begin bad++; $display("FAIL l2c3_window got=%h exp=232221131211030201", cap_d[b0+2][3]); end
        for (int ln = 0; ln < 3; ln++)
            for (int col = 0; col < 4; col++) begin
                total += 4;
                if (cap_d[b0+ln][col] !== exp_win(ln, col)) begin
                    bad++; $display("FAIL win_l%0d_c%0d got=%h exp=%h", ln, col, cap_d[b0+ln][col], exp_win(ln, col));
                end
                if (cap_rv[b0+ln][col] !== {1'b1, ln >= 1, ln >= 2}) begin
                    bad++; $display("FAIL rowvalid_l%0d_c%0d got=%b exp=%b", ln, col, cap_rv[b0+ln][col], {1'b1, ln >= 1, ln >= 2});
                end
                if (cap_cv[b0+ln][col] !== {1'b1, col >= 1, col >= 2}) begin
                    bad++; $display("FAIL colvalid_l%0d_c%0d got=%b exp=%b", ln, col, cap_cv[b0+ln][col], {1'b1, col >= 1, col >= 2});
                end
                if (cap_wv[b0+ln][col] !== (ln >= 2 && col >= 2)) begin
                    bad++; $display("FAIL wv_l%0d_c%0d got=%b exp=%b", ln, col, cap_wv[b0+ln][col], (ln >= 2 && col >= 2));
                end
            end
    endtask

    task automatic test_reset_midline;
        int b0;
        drive_line(0, 4, 0, 1);
        den = 1'b1; pix = 8'd16; step;
        pix = 8'd17; step;
        den = 1'b0; pix = 8'd0; rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        step;
        b0 = ob + 1;
        drive_line(0, 4, -1, 1);
        drive_line(1, 4, -1, 1);
        drive_line(2, 4, -1, 3);
        total += 4;
        if (ob - b0 + 1 !== 3) begin bad++; $display("FAIL rst_bursts got=%0d exp=3", ob - b0 + 1); end
        if (lc !== 16'd3) begin bad++; $display("FAIL rst_linecount got=%0d exp=3", lc); end
        if (cap_d[b0+2][2] !== 72'h22_21_20_12_11_10_02_01_00) begin bad++; $display("FAIL rst_l2c2 got=%h exp=222120121110020100", cap_d[b0+2][2]); end
        if (cap_d[b0+2][3] !== 72'h23_22_21_13_12_11_03_02_01) begin bad++; $display("FAIL rst_l2c3 got=%h exp=232221131211030201", cap_d[b0+2][3]); end
        for (int col = 0; col < 4; col++) begin
            total++;
            if (cap_d[b0][col] !== exp_win(0, col)) begin
                bad++; $display("FAIL rst_line0_c%0d got=%h exp=%h", col, cap_d[b0][col], exp_win(0, col));
            end
        end
    endtask

    task automatic test_overflow;
        for (int col = 0; col < 17; col++) begin
            den = 1'b1;
            fs  = (col == 0);
            pix = 8'(col);
            step;
            if (col == 15) begin
                total++;
                if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_at16 got=%b exp=0", ovf); end
            end
        end
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_at17 got=%b exp=1", ovf); end
        den = 1'b0; fs = 1'b0; pix = 8'd0;
        step;
        drive_line(1, 4, -1, 3);
        total += 2;
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
        if (lc !== 16'd2) begin bad++; $display("FAIL ovf_linecount got=%0d exp=2", lc); end
        drive_line(0, 4, 0, 3);
        total += 2;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
        if (lc !== 16'd1) begin bad++; $display("FAIL ovf_fs_linecount got=%0d exp=1", lc); end
    endtask

    task automatic test_frame_midline;
        int b0;
        b0 = ob + 1;
        drive_line(0, 4, 0, 1);
        drive_line(1, 4, -1, 1);
        drive_line(2, 4, 2, 3);
        total += 2;
        if (lc !== 16'd3) begin bad++; $display("FAIL midfs_linecount got=%0d exp=3", lc); end
        if (cap_rv[b0+2][3] !== 3'b111) begin bad++; $display("FAIL midfs_rowvalid got=%b exp=111", cap_rv[b0+2][3]); end
        drive_line(0, 4, 0, 1);
        drive_line(1, 4, -1, 1);
        drive_line(0, 4, 0, 3);
        total += 5;
        if (cap_rv[b0+3][0] !== 3'b100) begin bad++; $display("FAIL fs_rowvalid_a got=%b exp=100", cap_rv[b0+3][0]); end
        if (cap_rv[b0+4][0] !== 3'b110) begin bad++; $display("FAIL fs_rowvalid_b got=%b exp=110", cap_rv[b0+4][0]); end
        if (cap_rv[b0+5][0] !== 3'b100) begin bad++; $display("FAIL fs_coincident_rowvalid got=%b exp=100", cap_rv[b0+5][0]); end
        if (cap_d[b0+5][3] !== exp_win(0, 3)) begin bad++; $display("FAIL fs_coincident_data got=%h exp=%h", cap_d[b0+5][3], exp_win(0, 3)); end
        if (lc !== 16'd1) begin bad++; $display("FAIL fs_coincident_linecount got=%0d exp=1", lc); end
    endtask

    task automatic test_rgb;
        int b0;
        b0 = ob + 1;
        drive_line(0, 4, 0, 1);
        drive_line(1, 4, -1, 1);
        drive_line(2, 4, -1, 3);
        total += 2;
        if (lc3 !== 16'd3) begin bad++; $display("FAIL rgb_linecount got=%0d exp=3", lc3); end
        if (wv3 !== 1'b0 || rv3 !== 3'b111) begin bad++; $display("FAIL rgb_flags got=%b/%b exp=0/111", wv3, rv3); end
        for (int ln = 0; ln < 3; ln++)
            for (int col = 0; col < 4; col++) begin
                total++;
                if (cap3[b0+ln][col] !== exp_win3(ln, col)) begin
                    bad++; $display("FAIL rgb_l%0d_c%0d got=%h exp=%h", ln, col, cap3[b0+ln][col], exp_win3(ln, col));
                end
            end
    endtask

    initial begin
        test_reset;
        test_line0;
        test_three_lines;
        test_reset_midline;
        test_overflow;
        test_frame_midline;
        test_rgb;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
